line_buffer: RTL and testbench
==============================

# line_buffer

Single-line capture buffer between a camera pixel stream and a line-oriented consumer, such as a UDP packetizer behind a two-camera line-swap arbiter. On `trig`, it captures one full active line of `H_ACT` pixels from the packed camera stream, converts each pixel to RGB565 and holds the line. It then hands the line out word by word under `read_en`. Successive triggers walk through the rows `0..V_ACT-1` and wrap back to 0.

## Interface
- `H_ACT`, 1280: active pixels per line; also the line RAM depth.
- `V_ACT`, 720: active lines per frame; the row counter wraps here.

- `rclk` in 1: the only clock; the camera stream is synchronous to it.
- `rstn` in 1: reset, synchronous and active-low.
- `cam_pack` in 49: packed pixel, laid out as `{vsync[48], hsync[47], de[46], x[45:35], y[34:24], r[23:16], g[15:8], b[7:0]}`. `vsync` and `hsync` are ignored.
- `trig` in 1: capture request, sampled in IDLE only.
- `busy` out 1: high from trigger acceptance until the last word is read.
- `aquire` out 1: a complete line is held and unread words remain.
- `read_en` in 1: pops one pixel.
- `cam_data` out 16: RGB565 pixel, equal to `{r[7:3], g[7:2], b[7:3]}`.
- `cam_row` out 11: row number of the line being captured or held.
- `error` out 1: sticky fault flag.

## Operation
- Internal `target_row` (11 bits) resets to 0. `cam_row` always equals `target_row`.
- **IDLE:** `busy=0`, `aquire=0`. If `trig=1`, go to WAIT_LINE. `trig` is ignored in every other state.
- **WAIT_LINE:** wait for a beat with `de=1`, `y==target_row` and `x==0`. That beat is written to RAM[0] and the block enters CAPTURE. Beats for other rows or with `x!=0` are dropped.
- **CAPTURE:** every beat with `de=1` and `x==wr_ptr` is written to RAM[wr_ptr], and `wr_ptr` increments.
  - When RAM[`H_ACT-1`] is written, go to READY.
  - If `de=0` or `x!=wr_ptr` before the line completes, set `error`, reset `wr_ptr`, and return to WAIT_LINE for the same row (retry on the next frame).
- **READY:** `aquire=1`, read pointer at 0. Each cycle with `read_en=1` reads RAM[rd_ptr] and increments `rd_ptr`.
  - On the read where `rd_ptr==H_ACT-1`, go to IDLE.
  - On that same transition, `target_row` increments and wraps from `V_ACT-1` to 0.
- `read_en=1` while `aquire=0` is ignored and sets `error`.
- `error` clears only on reset.

## Timing
- **Reset:** `rstn=0` at a clock edge forces IDLE, all pointers to 0, `target_row=0`, `busy=0`, `aquire=0`, `cam_data=0`, `cam_row=0`, `error=0`. This applies mid-capture and mid-read; the partial line is discarded.
- **Trigger:** `trig` high at edge N in IDLE gives `busy=1` from N+1.
- **Capture:** the beat writing RAM[`H_ACT-1`] at edge M gives `aquire=1` from M+1.
- **Read latency is 1:**
  - `read_en` at edge K gives the corresponding pixel on `cam_data` from K+1.
  - `cam_data` holds its value when no read occurs.
  - Back-to-back `read_en` streams one pixel per cycle.
- **Line end:** the final read at edge L gives `aquire=0`, `busy=0` and the incremented `cam_row` from L+1, together with the last pixel on `cam_data`.
- **Simultaneous events:**
  - `trig` coinciding with the final read is ignored, because the state is not IDLE.
  - `trig` one cycle later is accepted.
- The RAM is one `H_ACT`×16 simple dual-port array in the same clock domain.

## Test plan
- **Reset values:** hold `rstn=0` with random inputs → all outputs 0. Release with no `trig` → `busy` stays 0 and `read_en` pulses set `error=1`.
- **Single line:** stream a frame with pixel `(x,y)` = `r=x[7:0]`, `g=y[7:0]`, `b=0xF8`, then pulse `trig` → `busy` next cycle; after row 0 completes, `aquire=1`, `cam_row=0`. 1280 back-to-back reads return `{x[7:3], 6'b0, 5'b11111}` with 1-cycle latency; `busy` and `aquire` fall one cycle after read 1280; `cam_row` becomes 1.
- **Row wrap:** use `H_ACT=8`, `V_ACT=3` and run 4 trig/read cycles → rows 0, 1, 2, 0 are captured, with correct `y`-derived data for each.
- **Short line:** drop `de` at `x=5` on the target row → `error=1`. The next frame's target row is captured correctly; `error` stays 1 until reset.
- **Trigger while busy:** pulse `trig` during CAPTURE and during READY → no extra capture; `cam_row` advances exactly once per completed read.
- **Reset mid-read:** assert `rstn=0` after 100 reads → outputs return to reset values. A new `trig` captures row 0 again.

Source files
------------

// File: rtl/line_buffer.sv
// Captures one active camera line on trigger, converts it to RGB565 and reads it back out word by word.
// Latency: a read_en accepted at edge K presents its pixel on cam_data from K+1; capture completes one cycle after the last beat.
// Backpressure: there is none on the camera side. A break in the line aborts the capture and it retries on the next frame. Reads are paced by read_en only.
module line_buffer #(
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720
) (
    input  logic        rclk,
    input  logic        rstn,
    input  logic [48:0] cam_pack,
    input  logic        trig,
    output logic        busy,
    output logic        aquire,
    input  logic        read_en,
    output logic [15:0] cam_data,
    output logic [10:0] cam_row,
    output logic        error
);

    localparam int          AW       = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam logic [10:0] LAST_X   = 11'(H_ACT - 1);
    localparam logic [10:0] LAST_ROW = 11'(V_ACT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        CAPTURE   = 2'd2,
        READY     = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [10:0] wr_ptr;
    logic [10:0] rd_ptr;
    logic [10:0] target_row;
    logic        wr_en;
    logic        abort;
    logic        rd_fire;

    logic [15:0] ram [H_ACT];

    // Field extraction from the packed camera beat.
    logic        px_de;
    logic [10:0] px_x;
    logic [10:0] px_y;
    logic [15:0] px_565;
    logic        unused_bits;

    assign px_de       = cam_pack[46];
    assign px_x        = cam_pack[45:35];
    assign px_y        = cam_pack[34:24];
    assign px_565      = {cam_pack[23:19], cam_pack[15:10], cam_pack[7:3]};
    // Sync flags and dropped colour LSBs are intentionally ignored.
    assign unused_bits = ^{cam_pack[48:47], cam_pack[18:16], cam_pack[9:8], cam_pack[2:0]};

    assign busy     = (state != IDLE);
    assign aquire   = (state == READY);
    assign cam_row  = target_row;

    // State register.
    always_ff @(posedge rclk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the write/abort/read strobes of the current cycle.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        abort     = 1'b0;
        rd_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_nxt = WAIT_LINE;
                end
            end
            WAIT_LINE: begin
                // wr_ptr is always 0 here, so the beat lands in RAM[0].
                if (px_de && (px_y == target_row) && (px_x == 11'd0)) begin
                    wr_en     = 1'b1;
                    state_nxt = (LAST_X == 11'd0) ? READY : CAPTURE;
                end
            end
            CAPTURE: begin
                if (px_de && (px_x == wr_ptr)) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST_X) begin
                        state_nxt = READY;
                    end
                end else begin
                    // Broken line: retry the same row on the next frame.
                    abort     = 1'b1;
                    state_nxt = WAIT_LINE;
                end
            end
            READY: begin
                if (read_en) begin
                    rd_fire = 1'b1;
                    if (rd_ptr == LAST_X) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write pointer: advances per stored beat, rewinds on abort or line completion.
    always_ff @(posedge rclk) begin
        if (!rstn) begin
            wr_ptr <= 11'd0;
        end else if (abort) begin
            wr_ptr <= 11'd0;
        end else if (wr_en) begin
            wr_ptr <= (wr_ptr == LAST_X) ? 11'd0 : wr_ptr + 11'd1;
        end
    end

    // Line RAM write port.
    always_ff @(posedge rclk) begin
        if (rstn && wr_en) begin
            ram[wr_ptr[AW-1:0]] <= px_565;
        end
    end

    // Read port: registered output word, held between reads.
    always_ff @(posedge rclk) begin
        if (!rstn) begin
            rd_ptr   <= 11'd0;
            cam_data <= 16'd0;
        end else if (rd_fire) begin
            cam_data <= ram[rd_ptr[AW-1:0]];
            rd_ptr   <= (rd_ptr == LAST_X) ? 11'd0 : rd_ptr + 11'd1;
        end
    end

    // Row counter steps once per fully consumed line and wraps at the frame height.
    always_ff @(posedge rclk) begin
        if (!rstn) begin
            target_row <= 11'd0;
        end else if (rd_fire && (rd_ptr == LAST_X)) begin
            target_row <= (target_row == LAST_ROW) ? 11'd0 : target_row + 11'd1;
        end
    end

    // Sticky fault: broken capture or a read with no line held.
    always_ff @(posedge rclk) begin
        if (!rstn) begin
            error <= 1'b0;
        end else if (abort || (read_en && (state != READY))) begin
            error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_line_buffer.sv
// Scoreboard bench for line_buffer: full-width lines, small frame height so the row counter wraps quickly.
module tb_line_buffer;

    localparam int H = 1280;
    localparam int V = 3;

    logic        rclk = 1'b0;
    logic        rstn = 1'b0;
    logic [48:0] cam_pack = '0;
    logic        trig = 1'b0;
    logic        read_en = 1'b0;
    logic        busy;
    logic        aquire;
    logic [15:0] cam_data;
    logic [10:0] cam_row;
    logic        error;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] sb [$];

    line_buffer #(.H_ACT(H), .V_ACT(V)) dut (
        .rclk     (rclk),
        .rstn     (rstn),
        .cam_pack (cam_pack),
        .trig     (trig),
        .busy     (busy),
        .aquire   (aquire),
        .read_en  (read_en),
        .cam_data (cam_data),
        .cam_row  (cam_row),
        .error    (error)
    );

    always #5 rclk = ~rclk;

    function automatic logic [7:0] g_of(input int y);
        logic [10:0] yy;
        yy = 11'(y);
        return {yy[5:0], 2'b01};
    endfunction

    function automatic logic [48:0] mk(input bit de, input int x, input int y);
        logic [10:0] xx;
        logic [10:0] yy;
        xx = 11'(x);
        yy = 11'(y);
        return {1'($urandom), 1'($urandom), de, xx, yy, xx[7:0], g_of(y), 8'hF8};
    endfunction

    function automatic logic [15:0] exp_pix(input int x, input int y);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = 8'(x);
        g = g_of(y);
        b = 8'hF8;
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    // Stream n beats of row y starting at x=0; optional de drop and trig pulse.
    task automatic send_row(input int y, input int n, input int drop_at, input int trig_at, input bit push);
        for (int x = 0; x < n; x++) begin
            @(negedge rclk);
            cam_pack = mk(x != drop_at, x, y);
            trig     = (x == trig_at);
            if (push && x != drop_at) sb.push_back(exp_pix(x, y));
        end
        @(negedge rclk);
        cam_pack = mk(1'b0, 0, 0);
        trig     = 1'b0;
    endtask

    // Issue n back-to-back reads, checking each word one cycle after its read edge.
    task automatic do_reads(input int n, input int trig_at);
        logic [15:0] pend;
        pend = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge rclk);
            if (i > 0) begin
                n_vec++;
                if (cam_data !== pend) begin
                    n_bad++;
                    $display("FAIL read_data[%0d]: cam_data=%h want %h", i - 1, cam_data, pend);
                end
                n_vec++;
                if (aquire !== 1'b1) begin
                    n_bad++;
                    $display("FAIL read_aquire[%0d]: aquire=%b want 1", i - 1, aquire);
                end
            end
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: queue size=0 want >0");
                pend = 'x;
            end else begin
                pend = sb.pop_front();
            end
            read_en = 1'b1;
            trig    = (i == trig_at);
        end
        @(negedge rclk);
        read_en = 1'b0;
        trig    = 1'b0;
        n_vec++;
        if (cam_data !== pend) begin
            n_bad++;
            $display("FAIL read_last: cam_data=%h want %h", cam_data, pend);
        end
    endtask

    // Trigger, capture one row (preceded by a foreign row that must be dropped), read it all.
    task automatic capture_row(input int row, input int trig_cap, input int trig_rd);
        @(negedge rclk);
        trig = 1'b1;
        @(negedge rclk);
        trig = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL cap_busy row%0d: busy=%b want 1", row, busy);
        end
        send_row((row + 1) % V, 30, -1, -1, 1'b0);
        send_row(row, H, -1, trig_cap, 1'b1);
        n_vec++;
        if (aquire !== 1'b1) begin
            n_bad++;
            $display("FAIL cap_aquire row%0d: aquire=%b want 1", row, aquire);
        end
        n_vec++;
        if (cam_row !== 11'(row)) begin
            n_bad++;
            $display("FAIL cap_row: cam_row=%0d want %0d", cam_row, row);
        end
        do_reads(H, trig_rd);
        n_vec++;
        if ({busy, aquire} !== 2'b00) begin
            n_bad++;
            $display("FAIL line_end row%0d: busy,aquire=%b want 00", row, {busy, aquire});
        end
        n_vec++;
        if (cam_row !== 11'((row + 1) % V)) begin
            n_bad++;
            $display("FAIL row_advance: cam_row=%0d want %0d", cam_row, (row + 1) % V);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if ({busy, aquire, cam_data, cam_row, error} !== '0) begin
            n_bad++;
            $display("FAIL %s: busy=%b aquire=%b data=%h row=%0d err=%b want all 0",
                     tag, busy, aquire, cam_data, cam_row, error);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge rclk);
            trig     = 1'($urandom);
            read_en  = 1'($urandom);
            cam_pack = 49'({$urandom, $urandom});
        end
        @(negedge rclk);
        check_reset_outputs("reset_hold");
        trig     = 1'b0;
        read_en  = 1'b0;
        cam_pack = '0;
        rstn     = 1'b1;
        repeat (3) @(negedge rclk);
        n_vec++;
        if ({busy, error} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy,error=%b want 00", {busy, error});
        end
        read_en = 1'b1;
        @(negedge rclk);
        read_en = 1'b0;
        n_vec++;
        if (error !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_read_error: error=%b want 1", error);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_read_busy: busy=%b want 0", busy);
        end
        rstn = 1'b0;
        @(negedge rclk);
        rstn = 1'b1;
        check_reset_outputs("reset_clear_error");
    endtask

    task automatic test_single_line;
        capture_row(0, -1, -1);
        n_vec++;
        if (error !== 1'b0) begin
            n_bad++;
            $display("FAIL single_error: error=%b want 0", error);
        end
        @(negedge rclk);
        n_vec++;
        if (cam_data !== exp_pix(H - 1, 0)) begin
            n_bad++;
            $display("FAIL data_hold: cam_data=%h want %h", cam_data, exp_pix(H - 1, 0));
        end
    endtask

    task automatic test_row_wrap;
        capture_row(1, -1, -1);
        capture_row(2, -1, -1);
        capture_row(0, -1, -1);
    endtask

    task automatic test_short_line;
        @(negedge rclk);
        trig = 1'b1;
        @(negedge rclk);
        trig = 1'b0;
        send_row(1, 10, 5, -1, 1'b0);
        n_vec++;
        if ({error, busy, aquire} !== 3'b110) begin
            n_bad++;
            $display("FAIL short_abort: error,busy,aquire=%b want 110", {error, busy, aquire});
        end
        send_row(1, H, -1, -1, 1'b1);
        n_vec++;
        if (aquire !== 1'b1) begin
            n_bad++;
            $display("FAIL retry_aquire: aquire=%b want 1", aquire);
        end
        do_reads(H, -1);
        n_vec++;
        if (cam_row !== 11'd2) begin
            n_bad++;
            $display("FAIL retry_row: cam_row=%0d want 2", cam_row);
        end
        n_vec++;
        if (error !== 1'b1) begin
            n_bad++;
            $display("FAIL error_sticky: error=%b want 1", error);
        end
    endtask

    task automatic test_back_to_back;
        // trig during capture and coinciding with the final read must both be ignored.
        capture_row(2, 100, H - 1);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: size=%0d want 0", sb.size());
        end
        trig = 1'b1;
        @(negedge rclk);
        trig = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL trig_after_end: busy=%b want 1", busy);
        end
    endtask

    task automatic test_reset_mid_read;
        send_row(0, H, -1, -1, 1'b1);
        n_vec++;
        if (aquire !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_aquire: aquire=%b want 1", aquire);
        end
        do_reads(100, -1);
        rstn = 1'b0;
        @(negedge rclk);
        rstn = 1'b1;
        sb.delete();
        check_reset_outputs("reset_mid_read");
        capture_row(0, -1, -1);
    endtask

    initial begin
        test_reset;
        test_single_line;
        test_row_wrap;
        test_short_line;
        test_back_to_back;
        test_reset_mid_read;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
